reg_file_scb: RTL and testbench
===============================

// Module: reg_file_scb
// PURPOSE
// - Parametrised CPU register file: 2 combinational read ports (RS, RT), 1 synchronous write port (RD).
// - Register 0 is hardwired to zero.
// - Integrated scoreboard: one pending-write counter per register, raised at issue and lowered at
//   writeback, so the pipeline front end stalls on RAW hazards.
// - Sits between decode (issue side) and writeback; generalises the 8x8-bit file to any width and depth.
// PARAMETERS
// - DATA_W  8  register width in bits.
// - NREGS   8  number of registers including r0; power of two, >= 2.
// - ADDR_W  $clog2(NREGS)  register address width.
// - CNT_W   2  pending-write counter width; max in-flight writes per register = 2**CNT_W-1.
// PORTS
// - clk        in   1       clock; all state updates on posedge.
// - reset      in   1       synchronous, active-high.
// - rs_addr    in   ADDR_W  read port S address.
// - rt_addr    in   ADDR_W  read port T address.
// - rs_data    out  DATA_W  read port S data, combinational.
// - rt_data    out  DATA_W  read port T data, combinational.
// - wr_en      in   1       writeback valid.
// - wr_addr    in   ADDR_W  writeback destination.
// - wr_data    in   DATA_W  writeback data.
// - issue_en   in   1       decode requests to issue an instruction.
// - issue_rd   in   ADDR_W  destination of issuing instruction; 0 = no destination.
// - issue_ok   out  1       issue accepted this cycle, combinational.
// - stall      out  1       issue_en & ~issue_ok.
// - busy_vec   out  NREGS   bit i = counter[i] != 0; bit 0 is always 0.
// - wb_err     out  1       sticky: writeback arrived to a register whose counter was 0.
// BEHAVIOUR
// - Reset (sync): all registers, all counters and wb_err go to 0.
//   - Comb outputs during reset: rs_data/rt_data = 0 for addr 0, otherwise the stored value.
//   - Pending writes in flight at reset are discarded; any later writeback to them sets wb_err.
// - Reads: addr 0 -> 0; otherwise file[addr], zero cycles latency.
// - Write: wr_en & wr_addr != 0 -> file[wr_addr] <= wr_data at posedge.
//   - wr_addr == 0: write ignored, counters untouched, no error.
// - rs_busy = counter[rs_addr] != 0 (0 for addr 0); rt_busy likewise.
// - issue_ok = issue_en & ~rs_busy & ~rt_busy & ~(issue_rd != 0 & counter[issue_rd] == MAX),
//   where MAX = 2**CNT_W-1.
//   - Saturated destination stalls (WAW depth limit); the counter never wraps.
// - Counter update per register r != 0, per cycle:
//   - +1 if (issue_ok & issue_rd == r).
//   - -1 if (wr_en & wr_addr == r & counter[r] != 0).
//   - Both events in the same cycle: net unchanged.
// - wr_en to r != 0 with counter[r] == 0:
//   - Data is still written and the counter stays 0.
//   - wb_err <= 1 unless an issue to r is accepted in that cycle; then the counter stays 0.
// - wb_err clears only on reset.
// - No internal FSM beyond the counters. The issue/writeback handshake is implicit: every accepted
//   issue with rd != 0 owes exactly one writeback.
// CONFIGURATION
// - RF_BYPASS_EN defined: write-through forwarding.
//   - If wr_en & wr_addr == rs_addr != 0, rs_data = wr_data in the same cycle; same rule for rt.
//   - rs_busy/rt_busy treat a register as free when counter == 1 and its writeback is present
//     this cycle, so a dependent issue is accepted in the writeback cycle.
// - RF_BYPASS_EN undefined:
//   - Written data is visible the cycle after the write.
//   - The busy check uses the registered counter only, so dependents issue one cycle after writeback.
// TESTING
// - Reset, then read every address: all read 0, busy_vec = 0, wb_err = 0.
//   Then write 0xA5 to r0: r0 still reads 0.
// - Issue rd=3, then next cycle issue with rs=3.
//   - The second issue stalls until wr_en to r3 (data 0x3C).
//   - Bypass on: accepted in the wb cycle and reads 0x3C. Bypass off: accepted one cycle later.
// - CNT_W=2: issue rd=5 three times, so counter = 3.
//   - A fourth issue to rd=5 gets stall = 1.
//   - One writeback to r5 -> counter = 2, and the next issue is accepted.
// - Same cycle: issue rd=2 and wr_en to r2 with counter 1 -> counter stays 1, busy_vec[2] = 1,
//   file[2] updated.
// - wr_en to r6 with counter 0 -> data written, wb_err = 1.
//   wb_err persists across later traffic and clears on reset.
// - Assert reset with counters nonzero and issue_en high -> next cycle all counters 0, file cleared,
//   issue_ok follows the comb rule.

Source files
------------

// File: rtl/reg_file_scb.sv
// Register file with two combinational read ports, one write port and a per-register
// pending-write scoreboard for RAW/WAW stalls. Define RF_BYPASS_EN for write-through forwarding.
module reg_file_scb #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = $clog2(NREGS),
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ok,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec,
  output logic              wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_file [NREGS];
  logic [CNT_W-1:0]  r_cnt  [NREGS];
  logic              r_wb_err;

  logic w_rs_busy;
  logic w_rt_busy;
  logic w_dst_full;
  logic w_issue_ok;
  logic w_wb_orphan;

  // Read ports; r0 reads zero, optional same-cycle forwarding of the writeback
  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : r_file[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : r_file[rt_addr];
`ifdef RF_BYPASS_EN
    if (wr_en && (wr_addr == rs_addr) && (rs_addr != '0)) rs_data = wr_data;
    if (wr_en && (wr_addr == rt_addr) && (rt_addr != '0)) rt_data = wr_data;
`endif
  end

  // Source hazards; with forwarding, a last outstanding write landing now frees the register
  always_comb begin
    w_rs_busy = (rs_addr != '0) && (r_cnt[rs_addr] != '0);
    w_rt_busy = (rt_addr != '0) && (r_cnt[rt_addr] != '0);
`ifdef RF_BYPASS_EN
    if (wr_en && (wr_addr == rs_addr) && (r_cnt[rs_addr] == CNT_ONE)) w_rs_busy = 1'b0;
    if (wr_en && (wr_addr == rt_addr) && (r_cnt[rt_addr] == CNT_ONE)) w_rt_busy = 1'b0;
`endif
  end

  assign w_dst_full  = (issue_rd != '0) && (r_cnt[issue_rd] == CNT_MAX);
  assign w_issue_ok  = issue_en && !w_rs_busy && !w_rt_busy && !w_dst_full;
  assign issue_ok    = w_issue_ok;
  assign stall       = issue_en && !w_issue_ok;
  assign wb_err      = r_wb_err;

  // A writeback with nothing pending is an error unless an issue to the same register absorbs it
  assign w_wb_orphan = wr_en && (wr_addr != '0) && (r_cnt[wr_addr] == '0) &&
                       !(w_issue_ok && (issue_rd == wr_addr));

  always_comb begin
    busy_vec    = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      busy_vec[i] = (r_cnt[ADDR_W'(i)] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_file[ADDR_W'(i)] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      r_file[wr_addr] <= wr_data;
    end
  end

  // Pending-write counters: issue raises, writeback lowers, coincident events cancel
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_cnt[ADDR_W'(i)] <= '0;
      end
    end else begin
      r_cnt[0] <= '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i))) begin
          if ((r_cnt[ADDR_W'(i)] != '0) && !(w_issue_ok && (issue_rd == ADDR_W'(i))))
            r_cnt[ADDR_W'(i)] <= r_cnt[ADDR_W'(i)] - CNT_ONE;
        end else if (w_issue_ok && (issue_rd == ADDR_W'(i))) begin
          r_cnt[ADDR_W'(i)] <= r_cnt[ADDR_W'(i)] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)            r_wb_err <= 1'b0;
    else if (w_wb_orphan) r_wb_err <= 1'b1;
  end

endmodule

// File: tb/tb_reg_file_scb.sv
// Scoreboard bench for reg_file_scb: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file_scb;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rs_addr, rt_addr, wr_addr, issue_rd;
  logic [7:0] rs_data, rt_data, wr_data;
  logic       wr_en, issue_en, issue_ok, stall, wb_err;
  logic [7:0] busy_vec;

  int total = 0;
  int bad   = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string nm;
    int    ie;
    int    rs, rt, ok, busy, err;
  } exp_t;

  exp_t q[$];

  reg_file_scb dut (
    .clk(clk), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_ok(issue_ok), .stall(stall),
    .busy_vec(busy_vec), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int want);
    if (want >= 0) begin
      total++;
      if (act != want) begin
        bad++;
        $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, want);
      end
    end
  endtask

  // Monitor: outputs are combinational, so each driven cycle presents one response
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "rs_data", int'(rs_data), e.rs);
      chk(e.nm, "rt_data", int'(rt_data), e.rt);
      chk(e.nm, "issue_ok", int'(issue_ok), e.ok);
      if (e.ok >= 0) chk(e.nm, "stall", int'(stall), (e.ie != 0 && e.ok == 0) ? 1 : 0);
      chk(e.nm, "busy_vec", int'(busy_vec), e.busy);
      chk(e.nm, "wb_err", int'(wb_err), e.err);
    end
  end

  // One cycle of stimulus; -1 in an expectation field means not checked
  task automatic cyc(input string nm, input bit rst, input bit ie, input int ird,
                     input int rs, input int rt, input bit we, input int wa, input int wd,
                     input int e_rs, input int e_rt, input int e_ok, input int e_busy,
                     input int e_err);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    issue_en = ie;
    issue_rd = 3'(ird);
    rs_addr  = 3'(rs);
    rt_addr  = 3'(rt);
    wr_en    = we;
    wr_addr  = 3'(wa);
    wr_data  = 8'(wd);
    e.nm = nm; e.ie = int'(ie);
    e.rs = e_rs; e.rt = e_rt; e.ok = e_ok; e.busy = e_busy; e.err = e_err;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; issue_en = 1'b0; issue_rd = '0; rs_addr = '0; rt_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // reset, then read every register
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      cyc($sformatf("rd%0d", i), 0, 0, 0, i, 7 - i, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("wr_r0",  0, 0, 0, 0, 0, 1, 0, 'hA5, 0, 0, -1, 0, 0);
    cyc("rd_r0",  0, 0, 0, 0, 0, 0, 0, 0,    0, 0, -1, 0, 0);

    // RAW hazard on r3
    cyc("iss3",   0, 1, 3, 1, 2, 0, 0, 0,    0, 0, 1, 0, 0);
    cyc("raw_a",  0, 1, 4, 3, 0, 0, 0, 0,    0, 0, 0, 'h08, 0);
    cyc("raw_b",  0, 1, 4, 3, 0, 0, 0, 0,    0, 0, 0, 'h08, 0);
    if (BYP) begin
      cyc("raw_wb", 0, 1, 4, 3, 0, 1, 3, 'h3C, 'h3C, 0, 1, 'h08, 0);
      cyc("raw_nx", 0, 0, 0, 3, 0, 0, 0, 0,    'h3C, 0, 0, 'h10, 0);
    end else begin
      cyc("raw_wb", 0, 1, 4, 3, 0, 1, 3, 'h3C, 0, 0, 0, 'h08, 0);
      cyc("raw_nx", 0, 1, 4, 3, 0, 0, 0, 0,    'h3C, 0, 1, 0, 0);
    end
    cyc("wb4",    0, 0, 0, 0, 0, 1, 4, 'h44, -1, -1, 0, 'h10, 0);
    cyc("rd4",    0, 0, 0, 4, 3, 0, 0, 0,    'h44, 'h3C, 0, 0, 0);

    // WAW depth limit on r5 (CNT_W=2 -> max 3 in flight)
    cyc("sat1",   0, 1, 5, 0, 0, 0, 0, 0,    -1, -1, 1, 0, 0);
    cyc("sat2",   0, 1, 5, 0, 0, 0, 0, 0,    -1, -1, 1, 'h20, 0);
    cyc("sat3",   0, 1, 5, 0, 0, 0, 0, 0,    -1, -1, 1, 'h20, 0);
    cyc("sat4",   0, 1, 5, 0, 0, 0, 0, 0,    -1, -1, 0, 'h20, 0);
    cyc("sat_wb", 0, 0, 0, 0, 0, 1, 5, 'h55, -1, -1, 0, 'h20, 0);
    cyc("sat5",   0, 1, 5, 0, 0, 0, 0, 0,    -1, -1, 1, 'h20, 0);
    cyc("sat6",   0, 1, 5, 0, 0, 0, 0, 0,    -1, -1, 0, 'h20, 0);
    cyc("drn1",   0, 0, 0, 0, 0, 1, 5, 'h56, -1, -1, -1, 'h20, 0);
    cyc("drn2",   0, 0, 0, 0, 0, 1, 5, 'h56, -1, -1, -1, 'h20, 0);
    cyc("drn3",   0, 0, 0, 0, 0, 1, 5, 'h57, -1, -1, -1, 'h20, 0);
    cyc("drn_rd", 0, 0, 0, 5, 0, 0, 0, 0,    'h57, 0, 0, 0, 0);

    // coincident issue and writeback on r2
    cyc("co_iss", 0, 1, 2, 0, 0, 0, 0, 0,    -1, -1, 1, 0, 0);
    cyc("co_both",0, 1, 2, 0, 0, 1, 2, 'h22, 0, 0, 1, 'h04, 0);
    cyc("co_rd",  0, 0, 0, 2, 0, 0, 0, 0,    'h22, 0, 0, 'h04, 0);
    cyc("co_wb",  0, 0, 0, 0, 0, 1, 2, 'h23, -1, -1, 0, 'h04, 0);
    cyc("co_fin", 0, 0, 0, 2, 0, 0, 0, 0,    'h23, 0, 0, 0, 0);

    // orphan writeback sets the sticky error
    cyc("orph",   0, 0, 0, 0, 0, 1, 6, 'h66, 0, 0, 0, 0, 0);
    cyc("err1",   0, 1, 1, 6, 0, 0, 0, 0,    'h66, 0, 1, 0, 1);
    cyc("err2",   0, 0, 0, 0, 0, 1, 1, 'h11, -1, -1, 0, 'h02, 1);
    cyc("err3",   0, 0, 0, 1, 0, 0, 0, 0,    'h11, 0, 0, 0, 1);

    // reset with counters pending and issue_en high
    cyc("pre1",   0, 1, 7, 0, 0, 0, 0, 0,    -1, -1, 1, 0, 1);
    cyc("pre2",   0, 1, 7, 0, 0, 0, 0, 0,    -1, -1, 1, 'h80, 1);
    cyc("in_rst", 1, 1, 7, 6, 0, 0, 0, 0,    'h66, 0, 1, 'h80, 1);
    cyc("post",   0, 0, 0, 6, 2, 0, 0, 0,    0, 0, 0, 0, 0);
    cyc("post2",  0, 1, 1, 1, 5, 0, 0, 0,    0, 0, 1, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
